uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one Uart8 transmitter among NUM_REQ byte requesters with round-robin arbitration.
//   Latches the granted byte and drives txStart/in. Holds txStart until Uart8 reports txBusy,
//   then waits for the frame to finish and pulses a per-requester done.
//   Sits between producer blocks (status/log/command sources) and the tx side of Uart8.
// PARAMETERS
//   NUM_REQ        4      number of requesters, 2..8
//   START_TIMEOUT  65535  clk cycles allowed in START for txBusy to rise before abort
// PORTS
//   clk        in   1          system clock; all state on posedge
//   reset      in   1          asynchronous, active-high reset
//   enable     in   1          high: new grants allowed; also drives uartEn
//   req_valid  in   NUM_REQ    requester i has a byte; held until req_ready[i]
//   req_data   in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//   req_ready  out  NUM_REQ    one-cycle pulse: byte of requester i accepted
//   req_done   out  NUM_REQ    one-cycle pulse: frame of requester i fully sent
//   grant_id   out  3          index of requester owning the transmitter (valid when busy=1)
//   busy       out  1          state != IDLE
//   err        out  1          one-cycle pulse: START timed out
//   uartEn     out  1          to Uart8 txEn; equals enable, registered
//   txStart    out  1          to Uart8 txStart
//   txByte     out  8          to Uart8 in; stable from grant until return to IDLE
//   txBusy     in   1          from Uart8
//   txDone     in   1          from Uart8; not used for sequencing
// BEHAVIOUR
//   Reset: state=IDLE; txStart=0, txByte=0, req_ready=0, req_done=0, err=0, uartEn=0,
//     grant_id=0, rr_ptr=NUM_REQ-1. Reset mid-frame aborts immediately; no done/err pulse.
//   Arbitration: scan i = rr_ptr+1 .. rr_ptr+NUM_REQ (mod NUM_REQ); first with req_valid wins.
//   FSM:
//   IDLE:  if enable & |req_valid in cycle N: at edge N+1 latch txByte, grant_id, rr_ptr=winner.
//          Pulse req_ready[winner] and set txStart=1 during cycle N+1. -> START
//   START: txStart=1. If txBusy=1: txStart=0 next cycle -> BUSY.
//          Else timeout counter+1; at START_TIMEOUT: txStart=0, err pulse -> IDLE.
//   BUSY:  txStart=0. When txBusy=0: req_done[grant_id] pulse next cycle -> IDLE.
//   Back-to-back: a new grant may occur in the first IDLE cycle after done.
//     Gap between frames is 2 clk cycles plus the Uart8 start latency.
//   enable low mid-frame: the current frame completes, no new grants.
//     uartEn follows enable one cycle later. Uart8 behaviour on txEn=0 is its own.
//   Requester dropping req_valid before ready: simply not granted. No glitch on txStart.
//   Timeout counter: 16 bits min, cleared on entering START, saturates.
//   txStart never re-asserts within one grant, so Uart8 cannot double-send.
//   At most one bit of req_ready|req_done is set per cycle.
// TESTING
//   1. Single req0, data 8'h45 -> one req_ready[0]; rx loopback byte 01000101.
//      req_done[0] after ~10 baud periods; err=0.
//   2. All 4 valid simultaneously, data A0..A3 -> grant order 0,1,2,3.
//      Loopback receives A0,A1,A2,A3; then req1+req3 -> 1 then 3.
//   3. txBusy tied 0, START_TIMEOUT=16 -> txStart high 16 cycles, err pulse, back to IDLE.
//      Same requester re-granted next.
//   4. reset asserted mid-BUSY -> all outputs to reset values within the same clk.
//      No req_done; next request proceeds normally.
//   5. enable dropped during frame of req2 -> req_done[2] still pulses.
//      req0 pending is not granted until enable=1.
//   6. req_valid[1] held continuously with req0 -> alternates 0,1,0,1 (no starvation).

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the tx arbiter and the Uart8 transmit side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                 enable;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_done;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 err;
  logic                 uartEn;
  logic                 txStart;
  logic [7:0]           txByte;
  logic                 txBusy;
  logic                 txDone;

  // Arbiter side: takes requests and Uart8 status, drives grants and Uart8 controls.
  modport slave (
    input  enable, req_valid, req_data, txBusy, txDone,
    output req_ready, req_done, grant_id, busy, err, uartEn, txStart, txByte
  );

  // Producer / Uart8 side: the mirror image of the arbiter view.
  modport master (
    output enable, req_valid, req_data, txBusy, txDone,
    input  req_ready, req_done, grant_id, busy, err, uartEn, txStart, txByte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one Uart8 transmitter among NUM_REQ byte producers.
// A grant latches the byte, raises txStart until Uart8 reports txBusy, then waits for the
// frame to end and pulses the owner's done. A START that never sees txBusy aborts with err.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 65535
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = ($clog2(START_TIMEOUT + 1) > 16) ? $clog2(START_TIMEOUT + 1) : 16;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] COUNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_rrPtr;
  logic [2:0]         r_grantId;
  logic [7:0]         r_txByte;
  logic               r_txStart;
  logic               r_err;
  logic               r_uartEn;
  logic [NUM_REQ-1:0] r_reqReady;
  logic [NUM_REQ-1:0] r_reqDone;
  logic [TW-1:0]      r_timeout;

  logic               w_found;
  logic [IW-1:0]      w_winner;
  logic [IW-1:0]      w_scanIdx;
  logic [7:0]         w_reqBytes [NUM_REQ];
  logic               w_unusedTxDone;

  // txDone is redundant with the falling edge of txBusy, which is what sequences the FSM.
  assign w_unusedTxDone = bus.txDone;

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : gUnpack
    assign w_reqBytes[g] = bus.req_data[8*g +: 8];
  end

  // Round-robin scan starting just after the last winner; the first valid requester wins.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_scanIdx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_scanIdx = IW'((int'(r_rrPtr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[w_scanIdx]) begin
        w_found  = 1'b1;
        w_winner = w_scanIdx;
      end
    end
  end

  // Main FSM with registered outputs; rr pointer always equals the current owner while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rrPtr    <= IW'(NUM_REQ - 1);
      r_grantId  <= '0;
      r_txByte   <= '0;
      r_txStart  <= 1'b0;
      r_err      <= 1'b0;
      r_uartEn   <= 1'b0;
      r_reqReady <= '0;
      r_reqDone  <= '0;
      r_timeout  <= '0;
    end else begin
      r_uartEn   <= bus.enable;
      r_reqReady <= '0;
      r_reqDone  <= '0;
      r_err      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.enable && w_found) begin
            r_state              <= START;
            r_txStart            <= 1'b1;
            r_txByte             <= w_reqBytes[w_winner];
            r_grantId            <= 3'(w_winner);
            r_rrPtr              <= w_winner;
            r_reqReady[w_winner] <= 1'b1;
            r_timeout            <= '0;
          end
        end
        START: begin
          if (bus.txBusy) begin
            r_txStart <= 1'b0;
            r_state   <= BUSY;
          end else if (r_timeout == TIMEOUT_LAST) begin
            r_txStart <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= IDLE;
          end else if (r_timeout != COUNT_MAX) begin
            r_timeout <= r_timeout + TW'(1);
          end
        end
        BUSY: begin
          if (!bus.txBusy) begin
            r_reqDone[r_rrPtr] <= 1'b1;
            r_state            <= IDLE;
          end
        end
        default: begin
          r_txStart <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_reqReady;
  assign bus.req_done  = r_reqDone;
  assign bus.grant_id  = r_grantId;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err       = r_err;
  assign bus.uartEn    = r_uartEn;
  assign bus.txStart   = r_txStart;
  assign bus.txByte    = r_txByte;

endmodule
